// File: rtl/npc_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one AXI arbiter in front of the address crossbar.
// The accepted address is held on imd from issue until the last R beat / B handshake.

package npc_axi_pkg;
    typedef struct packed {
        logic        arvalid;
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        rready;
    } axi_r_m2s_t;

    typedef struct packed {
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        rlast;
    } axi_r_s2m_t;

    typedef struct packed {
        logic        awvalid;
        logic [31:0] awaddr;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        wvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        bready;
    } axi_w_m2s_t;

    typedef struct packed {
        logic awready;
        logic wready;
        logic bvalid;
    } axi_w_s2m_t;
endpackage

module npc_axi_arbiter
    import npc_axi_pkg::*;
#(
    parameter bit RR_EN    = 1'b1,
    parameter bit PRIO_RST = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  axi_r_m2s_t ifu_r_m2s,
    output axi_r_s2m_t ifu_r_s2m,
    input  axi_r_m2s_t lsu_r_m2s,
    output axi_r_s2m_t lsu_r_s2m,
    input  axi_w_m2s_t lsu_w_m2s,
    output axi_w_s2m_t lsu_w_s2m,
    output axi_r_m2s_t imd_r_m2s,
    input  axi_r_s2m_t imd_r_s2m,
    output axi_w_m2s_t imd_w_m2s,
    input  axi_w_s2m_t imd_w_s2m
);
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

    r_state_t    r_state, r_state_nxt;
    logic        r_owner, r_owner_nxt;   // 1 = LSU owns the read channel
    logic        prio, prio_nxt;         // 1 = LSU wins a tie
    logic        r_lat, grant_lsu, owner_rready;
    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;

    w_state_t    w_state, w_state_nxt;
    logic        w_lat;
    logic [31:0] w_addr;
    logic [7:0]  w_len;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;

    // ---------------- read path ----------------
    always_comb begin
        r_state_nxt  = r_state;
        r_owner_nxt  = r_owner;
        prio_nxt     = prio;
        r_lat        = 1'b0;
        ifu_r_s2m    = '0;
        lsu_r_s2m    = '0;
        imd_r_m2s    = '0;
        imd_r_m2s.araddr  = r_addr;
        imd_r_m2s.arlen   = r_len;
        imd_r_m2s.arsize  = r_size;
        imd_r_m2s.arburst = r_burst;
        ifu_r_s2m.rdata   = imd_r_s2m.rdata;
        ifu_r_s2m.rlast   = imd_r_s2m.rlast;
        lsu_r_s2m.rdata   = imd_r_s2m.rdata;
        lsu_r_s2m.rlast   = imd_r_s2m.rlast;
        owner_rready = r_owner ? lsu_r_m2s.rready : ifu_r_m2s.rready;

        if (ifu_r_m2s.arvalid && lsu_r_m2s.arvalid)
            grant_lsu = RR_EN ? prio : 1'b1;
        else
            grant_lsu = lsu_r_m2s.arvalid;

        case (r_state)
            R_IDLE: begin
                ifu_r_s2m.arready = ~reset & ifu_r_m2s.arvalid & ~grant_lsu;
                lsu_r_s2m.arready = ~reset & grant_lsu;
                if (~reset && (ifu_r_m2s.arvalid || lsu_r_m2s.arvalid)) begin
                    r_lat       = 1'b1;
                    r_owner_nxt = grant_lsu;
                    r_state_nxt = R_ADDR;
                end
            end
            R_ADDR: begin
                imd_r_m2s.arvalid = ~reset;
                if (imd_r_s2m.arready)
                    r_state_nxt = R_DATA;
            end
            R_DATA: begin
                imd_r_m2s.rready = ~reset & owner_rready;
                if (r_owner)
                    lsu_r_s2m.rvalid = ~reset & imd_r_s2m.rvalid;
                else
                    ifu_r_s2m.rvalid = ~reset & imd_r_s2m.rvalid;
                if (imd_r_s2m.rvalid && owner_rready && imd_r_s2m.rlast) begin
                    r_state_nxt = R_IDLE;
                    if (RR_EN)
                        prio_nxt = ~r_owner;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= R_IDLE;
            r_owner <= 1'b0;
            prio    <= PRIO_RST;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
        end else begin
            r_state <= r_state_nxt;
            r_owner <= r_owner_nxt;
            prio    <= prio_nxt;
            if (r_lat) begin
                r_addr  <= r_owner_nxt ? lsu_r_m2s.araddr  : ifu_r_m2s.araddr;
                r_len   <= r_owner_nxt ? lsu_r_m2s.arlen   : ifu_r_m2s.arlen;
                r_size  <= r_owner_nxt ? lsu_r_m2s.arsize  : ifu_r_m2s.arsize;
                r_burst <= r_owner_nxt ? lsu_r_m2s.arburst : ifu_r_m2s.arburst;
            end
        end
    end

    // ---------------- write path (LSU only) ----------------
    always_comb begin
        w_state_nxt = w_state;
        w_lat       = 1'b0;
        lsu_w_s2m   = '0;
        imd_w_m2s   = '0;
        imd_w_m2s.awaddr  = w_addr;
        imd_w_m2s.awlen   = w_len;
        imd_w_m2s.awsize  = w_size;
        imd_w_m2s.awburst = w_burst;
        imd_w_m2s.wdata   = lsu_w_m2s.wdata;
        imd_w_m2s.wstrb   = lsu_w_m2s.wstrb;
        imd_w_m2s.wlast   = lsu_w_m2s.wlast;

        case (w_state)
            W_IDLE: begin
                lsu_w_s2m.awready = ~reset;
                if (~reset && lsu_w_m2s.awvalid) begin
                    w_lat       = 1'b1;
                    w_state_nxt = W_ADDR;
                end
            end
            W_ADDR: begin
                imd_w_m2s.awvalid = ~reset;
                if (imd_w_s2m.awready)
                    w_state_nxt = W_DATA;
            end
            W_DATA: begin
                imd_w_m2s.wvalid = ~reset & lsu_w_m2s.wvalid;
                lsu_w_s2m.wready = ~reset & imd_w_s2m.wready;
                if (lsu_w_m2s.wvalid && imd_w_s2m.wready && lsu_w_m2s.wlast)
                    w_state_nxt = W_RESP;
            end
            W_RESP: begin
                lsu_w_s2m.bvalid = ~reset & imd_w_s2m.bvalid;
                imd_w_m2s.bready = ~reset & lsu_w_m2s.bready;
                if (imd_w_s2m.bvalid && lsu_w_m2s.bready)
                    w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            w_state <= W_IDLE;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
        end else begin
            w_state <= w_state_nxt;
            if (w_lat) begin
                w_addr  <= lsu_w_m2s.awaddr;
                w_len   <= lsu_w_m2s.awlen;
                w_size  <= lsu_w_m2s.awsize;
                w_burst <= lsu_w_m2s.awburst;
            end
        end
    end

endmodule
